// File: rtl/fp16_mul_seq.sv
// Sequencer around a combinational FP16 multiplier: classifies operands, resolves
// NaN/inf/zero directly, pre-normalises one subnormal operand and re-biases the product.
module fp16_mul_seq #(
  parameter int          EXP_BIAS = 15,
  parameter logic [15:0] NAN_CODE = 16'h7E00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic        out_inf,
  output logic        out_zero,
  output logic        out_nan,
  output logic        out_normal,
  output logic [15:0] mul_na,
  output logic [15:0] mul_nb,
  input  logic [15:0] mul_product
);

  localparam logic [4:0] EXP_MAX = 5'(2 * EXP_BIAS + 1);

  // flag vector layout: {inf, zero, nan, normal}
  localparam logic [3:0] F_INF  = 4'b1000;
  localparam logic [3:0] F_ZERO = 4'b0100;
  localparam logic [3:0] F_NAN  = 4'b0010;
  localparam logic [3:0] F_NORM = 4'b0001;

  typedef enum logic [2:0] {IDLE, CLASS, NORM, EXEC, ADJ, DONE} state_t;

  state_t      state_reg, state_next;
  logic [15:0] a_reg, b_reg;
  logic [14:0] prod_reg;
  logic [15:0] res_reg;
  logic [3:0]  flags_reg;
  logic [3:0]  k_reg;
  logic [10:0] mant_reg;
  logic        norm_a_reg, norm_b_reg;

  logic [15:0] opnd [2];
  logic [1:0]  is_nan, is_inf, is_zero, is_sub;
  logic        sign;
  logic [10:0] mant_shift;
  logic [15:0] spec_res, adj_res;
  logic [3:0]  spec_flags, adj_flags;
  logic [4:0]  prod_exp;
  logic [5:0]  exp_adj;
  logic        unused_bits;

  assign opnd[0]     = a_reg;
  assign opnd[1]     = b_reg;
  assign sign        = a_reg[15] ^ b_reg[15];
  assign mant_shift  = mant_reg << 1;
  assign unused_bits = mul_product[15];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_class
      assign is_nan[gi]  = (opnd[gi][14:10] == EXP_MAX) && (opnd[gi][9:0] != 10'd0);
      assign is_inf[gi]  = (opnd[gi][14:10] == EXP_MAX) && (opnd[gi][9:0] == 10'd0);
      assign is_zero[gi] = (opnd[gi][14:10] == 5'd0)    && (opnd[gi][9:0] == 10'd0);
      assign is_sub[gi]  = (opnd[gi][14:10] == 5'd0)    && (opnd[gi][9:0] != 10'd0);
    end
  endgenerate

  // Special-case result chosen in CLASS; only consumed on the CLASS -> DONE path.
  always_comb begin
    spec_res   = {sign, 15'h0};
    spec_flags = F_ZERO;
    if ((|is_nan) || (is_inf[0] && is_zero[1]) || (is_zero[0] && is_inf[1])) begin
      spec_res   = NAN_CODE;
      spec_flags = F_NAN;
    end else if (|is_inf) begin
      spec_res   = {sign, 5'h1F, 10'h0};
      spec_flags = F_INF;
    end
  end

  // Undo the exponent borrowed by pre-normalisation; underflow flushes to zero.
  always_comb begin
    prod_exp  = prod_reg[14:10];
    exp_adj   = {1'b0, prod_exp} - {2'b00, k_reg};
    adj_res   = {sign, 15'h0};
    adj_flags = F_ZERO;
    if (prod_exp == EXP_MAX) begin
      adj_res   = {sign, 5'h1F, 10'h0};
      adj_flags = F_INF;
    end else if (prod_exp != 5'd0 && !exp_adj[5] && exp_adj != 6'd0) begin
      adj_res   = {sign, exp_adj[4:0], prod_reg[9:0]};
      adj_flags = F_NORM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_result = 16'h0;
    out_inf    = 1'b0;
    out_zero   = 1'b0;
    out_nan    = 1'b0;
    out_normal = 1'b0;
    mul_na     = 16'h0;
    mul_nb     = 16'h0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = CLASS;
      end
      CLASS: begin
        if ((|is_nan) || (|is_inf) || (|is_zero) || (&is_sub)) state_next = DONE;
        else if (|is_sub) state_next = NORM;
        else state_next = EXEC;
      end
      NORM: begin
        if (mant_shift[10]) state_next = EXEC;
      end
      EXEC: begin
        mul_na = norm_a_reg ? {a_reg[15], 5'd1, mant_reg[9:0]} : a_reg;
        mul_nb = norm_b_reg ? {b_reg[15], 5'd1, mant_reg[9:0]} : b_reg;
        state_next = ADJ;
      end
      ADJ: begin
        state_next = DONE;
      end
      DONE: begin
        out_valid  = 1'b1;
        out_result = res_reg;
        {out_inf, out_zero, out_nan, out_normal} = flags_reg;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg      <= 16'h0;
      b_reg      <= 16'h0;
      prod_reg   <= 15'h0;
      res_reg    <= 16'h0;
      flags_reg  <= 4'h0;
      k_reg      <= 4'h0;
      mant_reg   <= 11'h0;
      norm_a_reg <= 1'b0;
      norm_b_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg <= in_a;
            b_reg <= in_b;
          end
        end
        CLASS: begin
          k_reg      <= 4'h0;
          norm_a_reg <= is_sub[0];
          norm_b_reg <= is_sub[1];
          mant_reg   <= is_sub[0] ? {1'b0, a_reg[9:0]} : {1'b0, b_reg[9:0]};
          res_reg    <= spec_res;
          flags_reg  <= spec_flags;
        end
        NORM: begin
          mant_reg <= mant_shift;
          k_reg    <= k_reg + 4'd1;
        end
        EXEC: begin
          prod_reg <= mul_product[14:0];
        end
        ADJ: begin
          res_reg   <= adj_res;
          flags_reg <= adj_flags;
        end
        default: ;
      endcase
    end
  end

endmodule
